// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and
//   load/store (LS). One transaction is outstanding at a time. Simultaneous
//   requests are granted round-robin, and IF wins the first tie after reset.
//   Sequence: IDLE (grant) -> ISSUE (mem_req_valid_o) -> WAIT (response) -> IDLE.
//   The owner's rsp_valid pulses one cycle after the memory response.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   if_req_*_i/_o             fetch request handshake and address
//   if_rsp_valid_o/data_o     fetch response pulse and data
//   ls_req_*_i/_o             load/store request handshake, addr/wen/wdata/wstrb
//   ls_rsp_valid_o/data_o     load data or store ack (data 0 for stores)
//   mem_req_valid_o/ready_i   memory request handshake
//   mem_addr/wen/wdata/wstrb_o registered request fields
//   mem_rsp_valid_i/data_i    memory response
//   busy_o                    transaction in flight
//   timeout_err_o             sticky watchdog flag
//
// Build option
//   ARB_TIMEOUT_EN : watchdog. It aborts a transaction after TIMEOUT cycles
//                    in ISSUE/WAIT and returns 32'hDEAD_BEEF to the owner.
//                    If undefined, the arbiter waits forever and timeout_err_o is 0.
//
// state  | meaning
// IDLE   | readies live, grant on any valid request
// ISSUE  | mem_req_valid_o high, waiting for mem_req_ready_i
// WAIT   | request accepted by memory, waiting for mem_rsp_valid_i
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_valid_i,
    output logic                  if_req_ready_o,
    input  logic [ADDR_W-1:0]     if_req_addr_i,
    output logic                  if_rsp_valid_o,
    output logic [DATA_W-1:0]     if_rsp_data_o,
    input  logic                  ls_req_valid_i,
    output logic                  ls_req_ready_o,
    input  logic [ADDR_W-1:0]     ls_req_addr_i,
    input  logic                  ls_req_wen_i,
    input  logic [DATA_W-1:0]     ls_req_wdata_i,
    input  logic [DATA_W/8-1:0]   ls_req_wstrb_i,
    output logic                  ls_rsp_valid_o,
    output logic [DATA_W-1:0]     ls_rsp_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_wen_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_wstrb_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [DATA_W-1:0]     mem_rsp_data_i,
    output logic                  busy_o,
    output logic                  timeout_err_o
);

    localparam int   STRB_W = DATA_W / 8;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic                owner_q, last_grant_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_wen_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [STRB_W-1:0]   mem_wstrb_q;
    logic                if_rsp_valid_q, ls_rsp_valid_q;
    logic [DATA_W-1:0]   if_rsp_data_q, ls_rsp_data_q;

    logic                grant_if, grant_ls, accept;
    logic                rsp_hit, timeout_hit, done;
    logic [DATA_W-1:0]   rsp_word;

    // IF wins unless LS is also valid and IF was granted last.
    assign grant_if = if_req_valid_i && (!ls_req_valid_i || last_grant_q == OWN_LS);
    assign grant_ls = ls_req_valid_i && !grant_if;
    assign accept   = (state_q == ST_IDLE) && (grant_if || grant_ls);
    assign rsp_hit  = (state_q == ST_WAIT) && mem_rsp_valid_i;
    assign done     = rsp_hit || timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_err_q;

    // The counter reaches TIMEOUT on the cycle that sees CNT_LAST.
    // A real response arriving in that same cycle takes precedence.
    assign timeout_hit = (state_q != ST_IDLE) && (cnt_q == CNT_LAST) && !rsp_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if (state_q != ST_IDLE) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err_o = timeout_err_q;
    assign rsp_word = timeout_hit ? DATA_W'(32'hDEAD_BEEF)
                    : (mem_wen_q ? '0 : mem_rsp_data_i);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign timeout_err_o  = 1'b0;
    assign rsp_word       = mem_wen_q ? '0 : mem_rsp_data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (timeout_hit)          state_d = ST_IDLE;
                else if (mem_req_ready_i) state_d = ST_WAIT;
            end
            ST_WAIT:  if (done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if_req_ready_o  = (state_q == ST_IDLE) && grant_if;
        ls_req_ready_o  = (state_q == ST_IDLE) && grant_ls;
        mem_req_valid_o = (state_q == ST_ISSUE);
        busy_o          = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q        <= OWN_IF;
            last_grant_q   <= OWN_LS;
            mem_addr_q     <= '0;
            mem_wen_q      <= 1'b0;
            mem_wdata_q    <= '0;
            mem_wstrb_q    <= '0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ls_rsp_data_q  <= '0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if (accept) begin
                owner_q      <= grant_ls;
                last_grant_q <= grant_ls;
                mem_addr_q   <= grant_ls ? ls_req_addr_i : if_req_addr_i;
                mem_wen_q    <= grant_ls && ls_req_wen_i;
                mem_wdata_q  <= grant_ls ? ls_req_wdata_i : '0;
                mem_wstrb_q  <= (grant_ls && ls_req_wen_i) ? ls_req_wstrb_i : '0;
            end
            if (done) begin
                if (owner_q == OWN_LS) begin
                    ls_rsp_valid_q <= 1'b1;
                    ls_rsp_data_q  <= rsp_word;
                end else begin
                    if_rsp_valid_q <= 1'b1;
                    if_rsp_data_q  <= rsp_word;
                end
            end
        end
    end

    assign mem_addr_o     = mem_addr_q;
    assign mem_wen_o      = mem_wen_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_wstrb_o    = mem_wstrb_q;
    assign if_rsp_valid_o = if_rsp_valid_q;
    assign if_rsp_data_o  = if_rsp_data_q;
    assign ls_rsp_valid_o = ls_rsp_valid_q;
    assign ls_rsp_data_o  = ls_rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. It covers fetch, tie-break, store,
// backpressure, reset in WAIT with a stray response, and, when built with
// ARB_TIMEOUT_EN, the watchdog abort.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_valid_i, if_req_ready_o;
    logic [31:0] if_req_addr_i;
    logic        if_rsp_valid_o;
    logic [31:0] if_rsp_data_o;
    logic        ls_req_valid_i, ls_req_ready_o;
    logic [31:0] ls_req_addr_i;
    logic        ls_req_wen_i;
    logic [31:0] ls_req_wdata_i;
    logic [3:0]  ls_req_wstrb_i;
    logic        ls_rsp_valid_o;
    logic [31:0] ls_rsp_data_o;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        busy_o, timeout_err_o;

    int n_chk = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
        .if_req_addr_i(if_req_addr_i),
        .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
        .ls_req_valid_i(ls_req_valid_i), .ls_req_ready_o(ls_req_ready_o),
        .ls_req_addr_i(ls_req_addr_i), .ls_req_wen_i(ls_req_wen_i),
        .ls_req_wdata_i(ls_req_wdata_i), .ls_req_wstrb_i(ls_req_wstrb_i),
        .ls_rsp_valid_o(ls_rsp_valid_o), .ls_rsp_data_o(ls_rsp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
        .busy_o(busy_o), .timeout_err_o(timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; checks are made 2ns later.
    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        if_req_valid_i  = 1'b0;
        if_req_addr_i   = '0;
        ls_req_valid_i  = 1'b0;
        ls_req_addr_i   = '0;
        ls_req_wen_i    = 1'b0;
        ls_req_wdata_i  = '0;
        ls_req_wstrb_i  = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle_inputs();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Single fetch with an immediate ready and a response in the following cycle.
    task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] rdata);
        if_req_valid_i  = 1'b1;
        if_req_addr_i   = addr;
        mem_req_ready_i = 1'b1;
        settle();
        chk("fetch_c0_if_ready", if_req_ready_o, 1);
        chk("fetch_c0_ls_ready", ls_req_ready_o, 0);
        next_cyc();
        if_req_valid_i = 1'b0;
        settle();
        chk("fetch_c1_mem_valid", mem_req_valid_o, 1);
        chk("fetch_c1_mem_addr", mem_addr_o, addr);
        chk("fetch_c1_mem_wen", mem_wen_o, 0);
        chk("fetch_c1_busy", busy_o, 1);
        next_cyc();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = rdata;
        settle();
        chk("fetch_c2_mem_valid", mem_req_valid_o, 0);
        chk("fetch_c2_if_rsp", if_rsp_valid_o, 0);
        next_cyc();
        mem_rsp_valid_i = 1'b0;
        settle();
        chk("fetch_c3_if_rsp", if_rsp_valid_o, 1);
        chk("fetch_c3_if_data", if_rsp_data_o, rdata);
        chk("fetch_c3_ls_rsp", ls_rsp_valid_o, 0);
        chk("fetch_c3_busy", busy_o, 0);
        next_cyc();
        settle();
        chk("fetch_c4_if_rsp", if_rsp_valid_o, 0);
        chk("fetch_c4_if_data_hold", if_rsp_data_o, rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        settle();
        chk("rst_mem_valid", mem_req_valid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wen", mem_wen_o, 0);
        chk("rst_mem_wstrb", mem_wstrb_o, 0);
        chk("rst_if_rsp", if_rsp_valid_o, 0);
        chk("rst_ls_rsp", ls_rsp_valid_o, 0);
        chk("rst_if_data", if_rsp_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_terr", timeout_err_o, 0);
        chk("rst_ready", {if_req_ready_o, ls_req_ready_o}, 0);

        // single fetch
        fetch_txn(32'h8000_0000, 32'h0000_0013);

        // simultaneous IF and LS from reset: IF first, then LS
        do_reset();
        if_req_valid_i  = 1'b1;
        if_req_addr_i   = 32'h8000_0010;
        ls_req_valid_i  = 1'b1;
        ls_req_addr_i   = 32'h8000_0400;
        mem_req_ready_i = 1'b1;
        settle();
        chk("tie_c0_if_ready", if_req_ready_o, 1);
        chk("tie_c0_ls_ready", ls_req_ready_o, 0);
        next_cyc();
        settle();
        chk("tie_c1_mem_addr", mem_addr_o, 32'h8000_0010);
        chk("tie_c1_ls_ready", ls_req_ready_o, 0);
        next_cyc();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h0000_0111;
        settle();
        chk("tie_c2_mem_valid", mem_req_valid_o, 0);
        next_cyc();
        mem_rsp_valid_i = 1'b0;
        settle();
        chk("tie_c3_if_rsp", if_rsp_valid_o, 1);
        chk("tie_c3_if_data", if_rsp_data_o, 32'h0000_0111);
        chk("tie_c3_ls_ready", ls_req_ready_o, 1);
        chk("tie_c3_if_ready", if_req_ready_o, 0);
        chk("tie_c3_ls_rsp", ls_rsp_valid_o, 0);
        next_cyc();
        ls_req_valid_i = 1'b0;
        settle();
        chk("tie_c4_mem_valid", mem_req_valid_o, 1);
        chk("tie_c4_mem_addr", mem_addr_o, 32'h8000_0400);
        next_cyc();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h0000_0222;
        settle();
        chk("tie_c5_mem_valid", mem_req_valid_o, 0);
        next_cyc();
        mem_rsp_valid_i = 1'b0;
        settle();
        chk("tie_c6_ls_rsp", ls_rsp_valid_o, 1);
        chk("tie_c6_ls_data", ls_rsp_data_o, 32'h0000_0222);
        chk("tie_c6_if_rsp", if_rsp_valid_o, 0);
        chk("tie_c6_if_ready", if_req_ready_o, 1);
        next_cyc();
        if_req_valid_i = 1'b0;

        // store: the response data is 0 whatever the memory returns
        do_reset();
        ls_req_valid_i  = 1'b1;
        ls_req_wen_i    = 1'b1;
        ls_req_addr_i   = 32'h8000_0100;
        ls_req_wdata_i  = 32'hA5A5_A5A5;
        ls_req_wstrb_i  = 4'b0011;
        mem_req_ready_i = 1'b1;
        settle();
        chk("st_c0_ls_ready", ls_req_ready_o, 1);
        next_cyc();
        ls_req_valid_i = 1'b0;
        settle();
        chk("st_c1_mem_wen", mem_wen_o, 1);
        chk("st_c1_mem_wstrb", mem_wstrb_o, 4'b0011);
        chk("st_c1_mem_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        chk("st_c1_mem_addr", mem_addr_o, 32'h8000_0100);
        next_cyc();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hFFFF_FFFF;
        next_cyc();
        mem_rsp_valid_i = 1'b0;
        settle();
        chk("st_c3_ls_rsp", ls_rsp_valid_o, 1);
        chk("st_c3_ls_data", ls_rsp_data_o, 0);

        // load with backpressure: wen and wstrb are forced low, fields stay stable
        next_cyc();
        ls_req_valid_i = 1'b1;
        ls_req_wen_i   = 1'b0;
        ls_req_addr_i  = 32'h8000_0200;
        ls_req_wdata_i = 32'h5555_5555;
        ls_req_wstrb_i = 4'b1111;
        settle();
        chk("bp_c0_ls_ready", ls_req_ready_o, 1);
        next_cyc();
        ls_req_valid_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if_req_valid_i = 1'b1;
            if_req_addr_i  = 32'h8000_0020;
            settle();
            chk("bp_mem_valid", mem_req_valid_o, 1);
            chk("bp_mem_addr", mem_addr_o, 32'h8000_0200);
            chk("bp_mem_wen", mem_wen_o, 0);
            chk("bp_mem_wstrb", mem_wstrb_o, 0);
            chk("bp_readies", {if_req_ready_o, ls_req_ready_o}, 0);
            chk("bp_busy", busy_o, 1);
            next_cyc();
        end
        mem_req_ready_i = 1'b1;
        settle();
        chk("bp_c6_mem_valid", mem_req_valid_o, 1);
        next_cyc();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h1234_5678;
        settle();
        chk("bp_c7_if_ready", if_req_ready_o, 0);
        next_cyc();
        mem_rsp_valid_i = 1'b0;
        settle();
        chk("bp_c8_ls_rsp", ls_rsp_valid_o, 1);
        chk("bp_c8_ls_data", ls_rsp_data_o, 32'h1234_5678);
        chk("bp_c8_if_ready", if_req_ready_o, 1);
        next_cyc();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        settle();
        chk("rw_issue_addr", mem_addr_o, 32'h8000_0020);
        chk("rw_issue_wstrb", mem_wstrb_o, 0);

        // reset while in WAIT, then a stray response
        next_cyc();
        mem_req_ready_i = 1'b0;
        rst_i = 1'b1;
        settle();
        chk("rw_wait_busy", busy_o, 1);
        next_cyc();
        rst_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h0000_0BAD;
        settle();
        chk("rw_busy", busy_o, 0);
        chk("rw_if_rsp", if_rsp_valid_o, 0);
        chk("rw_mem_valid", mem_req_valid_o, 0);
        next_cyc();
        mem_rsp_valid_i = 1'b0;
        settle();
        chk("rw_stray_if_rsp", if_rsp_valid_o, 0);
        chk("rw_stray_ls_rsp", ls_rsp_valid_o, 0);
        chk("rw_stray_busy", busy_o, 0);
        chk("rw_stray_if_data", if_rsp_data_o, 0);
        next_cyc();
        fetch_txn(32'h8000_0004, 32'h0000_0093);

`ifdef ARB_TIMEOUT_EN
        // watchdog with TIMEOUT=8: memory never answers
        do_reset();
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h8000_0040;
        settle();
        chk("to_c0_if_ready", if_req_ready_o, 1);
        next_cyc();
        if_req_valid_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            settle();
            chk("to_mem_valid", mem_req_valid_o, 1);
            chk("to_if_rsp_early", if_rsp_valid_o, 0);
            chk("to_terr_early", timeout_err_o, 0);
            next_cyc();
        end
        settle();
        chk("to_if_rsp", if_rsp_valid_o, 1);
        chk("to_if_data", if_rsp_data_o, 32'hDEAD_BEEF);
        chk("to_terr", timeout_err_o, 1);
        chk("to_mem_valid_drop", mem_req_valid_o, 0);
        chk("to_busy", busy_o, 0);
        next_cyc();
        settle();
        chk("to_terr_sticky", timeout_err_o, 1);
        chk("to_if_rsp_once", if_rsp_valid_o, 0);
        do_reset();
        settle();
        chk("to_terr_cleared", timeout_err_o, 0);
`else
        chk("terr_tied_low", timeout_err_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
